// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - round-robin arbiter sequencing N_REQ requesters onto one shared iterative multiplier
// Optional macro MULT_ARB_TIMEOUT_EN: bound the wait on the multiplier to TIMEOUT cycles and flag resp_err.
module mult_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [W-1:0]       resp_y,
  output logic               resp_err,
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic               mul_busy,
  input  logic [W-1:0]       mul_y
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] id;
  logic [IDW-1:0] grant_id;
  logic           grant_found;
  logic [IDW:0]   rr_idx;
  logic [IDW:0]   id_inc;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           accept;
  logic           capture;
  logic           ack;
  logic           timed_out;

  // Scan offsets from high to low so the lowest offset from ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_idx = {1'b0, ptr} + (IDW + 1)'(k);
      if (rr_idx >= (IDW + 1)'(N_REQ)) begin
        rr_idx = rr_idx - (IDW + 1)'(N_REQ);
      end
      if (req_valid[rr_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    id_inc = {1'b0, id} + (IDW + 1)'(1);
    if (id_inc == (IDW + 1)'(N_REQ)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = id_inc[IDW-1:0];
    end
  end

  assign accept  = (state == IDLE) && grant_found;
  assign capture = (state == WAIT_DONE) && !mul_busy;
  assign ack     = resp_ready[id];

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting;

  assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
  // A normal completion in the same cycle as expiry takes precedence.
  assign timed_out = waiting && !capture && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (waiting && !timed_out) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (capture) begin
      resp_err <= 1'b0;
    end else if (timed_out) begin
      resp_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_found) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timed_out) begin
          state_nxt = RESP;
        end else if (mul_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: if (capture || timed_out) state_nxt = RESP;
      RESP:      if (ack) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mul_start  = (state == ISSUE);
    if (accept) begin
      req_ready = N_REQ'(1) << grant_id;
    end
    if (state == RESP) begin
      resp_valid = N_REQ'(1) << id;
    end
  end

  // Operands stay latched from accept until the next accept so the multiplier sees them stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      id     <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      resp_y <= '0;
    end else begin
      if (accept) begin
        id    <= grant_id;
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      if (capture) begin
        resp_y <= mul_y;
      end else if (timed_out) begin
        resp_y <= '0;
      end
      if ((state == RESP) && ack) begin
        ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative shift-add multiplier among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Drives the multiplier's start/operand port, tracks its busy flag and captures the product.
- Returns the product to the originating requester over a held valid/ready response.
- Sits between the client blocks and the single multiplier instance; the multiplier shares clk/reset.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 16, operand and result width
TIMEOUT, 32, max cycles waiting on the multiplier (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  request pending, one bit per requester
req_ready  out  N_REQ  one-hot acceptance pulse
req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W]
req_b  in  N_REQ*W  operand B, same packing
resp_valid  out  N_REQ  one-hot, held until acknowledged
resp_ready  in  N_REQ  response acknowledge per requester
resp_y  out  W  product for the requester flagged in resp_valid
resp_err  out  1  timeout flag qualifying resp_y (0 without the optional feature)
mul_start  out  1  start pulse to the multiplier
mul_a  out  W  operand A to the multiplier
mul_b  out  W  operand B to the multiplier
mul_busy  in  1  multiplier busy flag
mul_y  in  W  multiplier result, valid once busy falls

Behaviour:
- Reset (synchronous): state=IDLE, rr pointer=0. All of the following are 0: req_ready, resp_valid, resp_y, resp_err, mul_start, mul_a, mul_b, latched id.
- Reset mid-operation aborts the transaction with no response. The multiplier is reset by the same reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - Assert req_ready[g] combinationally in that cycle only; this is the accept cycle.
  - Latch req_a/req_b slice g and id=g, then go to ISSUE.
  - With no req_valid set, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; mul_a/mul_b hold the latched operands (held stable through WAIT_DONE). Go to WAIT_BUSY.
- WAIT_BUSY: when mul_busy=1, go to WAIT_DONE.
- WAIT_DONE:
  - When mul_busy=0, register mul_y into resp_y, clear resp_err and go to RESP.
  - No fixed busy length is assumed.
- RESP:
  - resp_valid[id]=1, with resp_y/resp_err held stable.
  - On resp_ready[id]=1: clear resp_valid, set pointer=(id+1) mod N_REQ, go to IDLE.
  - resp_ready from other requesters is ignored.
- req_ready is 0 in every state except IDLE. New requests wait; a requester may drop req_valid before it is accepted.
- Only one transaction is outstanding at a time. The next grant is earliest in the cycle after the response acknowledge.
- Nominal latency with an 8-cycle multiplier:
  - accept at T
  - mul_start at T+1
  - busy T+2..T+9
  - capture at T+10
  - resp_valid from T+11
- Fairness: a requester holding req_valid continuously is granted within N_REQ transactions.
- Only W bits of the product are returned; the multiplier's truncation is passed through unchanged.

Optional Feature:
Macro MULT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_BUSY and counts through WAIT_BUSY and WAIT_DONE.
  - If it reaches TIMEOUT before completion, go to RESP with resp_y=0 and resp_err=1.
  - The pointer advances normally.
- Not defined: no counter; resp_err is tied to 0 and the FSM waits indefinitely.

Test Plan:
- Single request: req0 a=3 b=5 -> req_ready[0] at T, mul_start at T+1, resp_valid[0] held with resp_y=15 until resp_ready[0].
- All four valid every cycle with a=i+2, b=3 -> grant order 0,1,2,3,0; resp_y=6,9,12,15 on the matching resp_valid bit.
- Response backpressure: hold resp_ready low 5 cycles -> resp_valid/resp_y stable; no req_ready asserted; mul_start stays 0.
- Pointer wrap: pointer=3, only req1 valid -> req1 granted; next pointer=2.
- Reset asserted in WAIT_DONE -> next cycle all outputs 0, state IDLE; a fresh request completes correctly.
- With MULT_ARB_TIMEOUT_EN and mul_busy stuck at 1 (stub multiplier) -> resp_err=1, resp_y=0 after TIMEOUT cycles; the next request is still served.
